// File: rtl/hamming_dec_engine.sv
// SECDED decoder: reads 16-bit codewords, writes 11-bit message + status.
// Ports: clk, reset (async low), start/done/busy, 8-bit data-memory port.
module hamming_dec_engine #(
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int NUM_WORDS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic       busy,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic [3:0] err1_count,
  output logic [3:0] err2_count
);

  typedef enum logic [2:0] {
    IDLE, RD_HI, RD_LO, WR_HI, WR_LO, DONE
  } state_t;

  localparam logic [7:0] SB   = 8'(SRC_BASE);
  localparam logic [7:0] DB   = 8'(DST_BASE);
  localparam logic [7:0] LAST = 8'(NUM_WORDS - 1);

  state_t      state, nxt;
  logic [7:0]  idx;
  logic [7:0]  hi, lo;
  logic [3:0]  e1, e2;

  logic [15:0] cw, fx;
  logic [3:0]  syn;
  logic        par;
  logic [1:0]  st;
  logic [10:0] dat;
  logic [7:0]  res_hi, res_lo;
  logic [7:0]  off;

  assign off        = {idx[6:0], 1'b0};
  assign err1_count = e1;
  assign err2_count = e2;

  always_comb begin
    cw  = {hi, lo};
    syn = '0;
    for (int k = 1; k < 16; k++)
      if (cw[k]) syn = syn ^ 4'(k);
    par = ^cw;
    fx  = cw;
    st  = 2'b00;
    if (par) begin
      st = 2'b01;
      // s=0 with odd parity means p0 itself flipped
      if (syn != 4'd0) fx[syn] = ~cw[syn];
    end else if (syn != 4'd0) begin
      st = 2'b10;
    end
    dat    = {fx[15:9], fx[7:5], fx[3]};
    res_hi = {st, 3'b000, dat[10:8]};
    res_lo = dat[7:0];
  end

  always_comb begin
    nxt         = state;
    done        = 1'b0;
    busy        = 1'b0;
    mem_addr    = 8'd0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) nxt = RD_HI;
      end
      RD_HI: begin
        busy     = 1'b1;
        mem_addr = SB + off + 8'd1;
        nxt      = RD_LO;
      end
      RD_LO: begin
        busy     = 1'b1;
        mem_addr = SB + off;
        nxt      = WR_HI;
      end
      WR_HI: begin
        busy        = 1'b1;
        mem_wr_en   = 1'b1;
        mem_addr    = DB + off + 8'd1;
        mem_wr_data = res_hi;
        nxt         = WR_LO;
      end
      WR_LO: begin
        busy        = 1'b1;
        mem_wr_en   = 1'b1;
        mem_addr    = DB + off;
        mem_wr_data = res_lo;
        nxt         = (idx == LAST) ? DONE : RD_HI;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      hi    <= '0;
      lo    <= '0;
      e1    <= '0;
      e2    <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx <= '0;
            e1  <= '0;
            e2  <= '0;
          end
        end
        RD_HI: hi <= mem_rd_data;
        RD_LO: lo <= mem_rd_data;
        WR_HI: begin
          if (st == 2'b01 && e1 != 4'd15) e1 <= e1 + 4'd1;
          if (st == 2'b10 && e2 != 4'd15) e2 <= e2 + 4'd1;
        end
        WR_LO: if (idx != LAST) idx <= idx + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Bench for hamming_dec_engine: table vectors, random runs vs
// a codebook-distance reference model, reset and handshake cases.
module tb_hamming_dec_engine;

  localparam int SB0 = 30, DB0 = 0, N0 = 15;
  localparam int SB1 = 40, DB1 = 100, N1 = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic       done0, done1, busy0, busy1;
  logic [7:0] a0, a1, rd0, rd1, wd0, wd1;
  logic       we0, we1;
  logic [3:0] e10, e20, e11, e21;
  logic       ld0 = 1'b0, ld1 = 1'b0;

  logic [7:0] mem0[256], mem1[256], img0[256], img1[256];

  always #5 clk = ~clk;

  hamming_dec_engine #(.SRC_BASE(SB0), .DST_BASE(DB0), .NUM_WORDS(N0)) u0 (
    .clk(clk), .reset(rst_n), .start(start0), .done(done0), .busy(busy0),
    .mem_addr(a0), .mem_rd_data(rd0), .mem_wr_en(we0),
    .mem_wr_data(wd0), .err1_count(e10), .err2_count(e20));

  hamming_dec_engine #(.SRC_BASE(SB1), .DST_BASE(DB1), .NUM_WORDS(N1)) u1 (
    .clk(clk), .reset(rst_n), .start(start1), .done(done1), .busy(busy1),
    .mem_addr(a1), .mem_rd_data(rd1), .mem_wr_en(we1),
    .mem_wr_data(wd1), .err1_count(e11), .err2_count(e21));

  assign rd0 = mem0[a0];
  assign rd1 = mem1[a1];

  always @(posedge clk) begin
    if (ld0) mem0 <= img0;
    else if (we0) mem0[a0] <= wd0;
  end

  always @(posedge clk) begin
    if (ld1) mem1 <= img1;
    else if (we1) mem1[a1] <= wd1;
  end

  int ncmp = 0, nfail = 0;

  typedef struct {
    logic [15:0] cw;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  logic [15:0] cb[2048];
  logic [15:0] cws[20];
  logic [7:0]  exp_hi[20], exp_lo[20];
  int          ex1, ex2;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] encode(input logic [10:0] m);
    logic [15:0] c = '0;
    int i = 0;
    for (int k = 1; k < 16; k++)
      if ((k & (k - 1)) != 0) begin
        c[k] = m[i];
        i++;
      end
    for (int p = 1; p < 16; p = p * 2) begin
      logic x = 1'b0;
      for (int k = 1; k < 16; k++)
        if ((k & p) != 0 && k != p) x ^= c[k];
      c[p] = x;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] r);
    logic [10:0] m = '0;
    int i = 0;
    for (int k = 1; k < 16; k++)
      if ((k & (k - 1)) != 0) begin
        m[i] = r[k];
        i++;
      end
    return m;
  endfunction

  // Nearest-codeword decode: distance 0 clean, 1 corrected, else double.
  task automatic ref_dec(input logic [15:0] r, output logic [1:0] st,
                         output logic [10:0] m);
    st = 2'b10;
    m  = extract(r);
    for (int j = 0; j < 2048; j++) begin
      int d = $countones(cb[j] ^ r);
      if (d == 0) begin
        st = 2'b00;
        m  = 11'(j);
      end else if (d == 1) begin
        st = 2'b01;
        m  = 11'(j);
      end
    end
  endtask

  task automatic prep(input int sel, input int n);
    logic [1:0]  st;
    logic [10:0] m;
    ex1 = 0;
    ex2 = 0;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) begin
        img0[SB0 + 2*i]     = cws[i][7:0];
        img0[SB0 + 2*i + 1] = cws[i][15:8];
      end else begin
        img1[SB1 + 2*i]     = cws[i][7:0];
        img1[SB1 + 2*i + 1] = cws[i][15:8];
      end
      ref_dec(cws[i], st, m);
      exp_hi[i] = {st, 3'b000, m[10:8]};
      exp_lo[i] = m[7:0];
      if (st == 2'b01) ex1++;
      if (st == 2'b10) ex2++;
    end
    if (ex1 > 15) ex1 = 15;
    if (ex2 > 15) ex2 = 15;
    @(negedge clk);
    if (sel == 0) ld0 = 1'b1; else ld1 = 1'b1;
    @(negedge clk);
    ld0 = 1'b0;
    ld1 = 1'b0;
  endtask

  task automatic check_res(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] got;
      if (sel == 0) got = {mem0[DB0 + 2*i + 1], mem0[DB0 + 2*i]};
      else          got = {mem1[DB1 + 2*i + 1], mem1[DB1 + 2*i]};
      chk($sformatf("result[%0d]", i), got, {exp_hi[i], exp_lo[i]});
    end
    chk("err1_count", (sel == 0) ? e10 : e11, ex1);
    chk("err2_count", (sel == 0) ? e20 : e21, ex2);
  endtask

  task automatic run(input int sel, input int n, input int glitch);
    int edges = 0;
    @(negedge clk);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    chk("accept_busy", (sel == 0) ? busy0 : busy1, 1);
    chk("accept_done", (sel == 0) ? done0 : done1, 0);
    if (sel == 0) chk("first_addr", a0, SB0 + 1);
    while (!((sel == 0) ? done0 : done1) && edges < 4*n + 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (sel == 0) start0 = (edges == glitch);
    end
    start0 = 1'b0;
    chk("run_length", edges, 4*n);
    chk("done_busy", (sel == 0) ? busy0 : busy1, 0);
    if (sel == 0) chk("done_idle_bus", {we0, a0, wd0}, 0);
  endtask

  function automatic logic [15:0] rnd_cw();
    return cb[$urandom_range(2047, 0)];
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tv[6];
    tv[0] = '{16'hFFFF, 8'h07, 8'hFF};
    tv[1] = '{16'hFFDF, 8'h47, 8'hFF};
    tv[2] = '{16'h7FFE, 8'h83, 8'hFF};
    tv[3] = '{16'h0000, 8'h00, 8'h00};
    tv[4] = '{16'h0001, 8'h40, 8'h00};
    tv[5] = '{16'h0003, 8'h80, 8'h00};

    for (int j = 0; j < 2048; j++) cb[j] = encode(11'(j));
    for (int j = 0; j < 256; j++) begin
      img0[j] = 8'h00;
      img1[j] = 8'h00;
    end

    // reset state
    #12;
    chk("rst_done", done0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_bus", {we0, a0, wd0}, 0);
    chk("rst_counts", {e10, e20}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // table vectors, padded with zero codewords
    for (int i = 0; i < N0; i++) cws[i] = (i < 6) ? tv[i].cw : 16'h0;
    prep(0, N0);
    run(0, N0, -1);
    check_res(0, N0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("table[%0d]", i),
          {mem0[DB0 + 2*i + 1], mem0[DB0 + 2*i]}, {tv[i].hi, tv[i].lo});
    chk("table_e1", e10, 2);
    chk("table_e2", e20, 2);

    // clean words
    for (int i = 0; i < N0; i++) cws[i] = rnd_cw();
    prep(0, N0);
    run(0, N0, -1);
    check_res(0, N0);
    chk("clean_e1", e10, 0);

    // word i with bit i flipped, then bit 15 on every word
    for (int i = 0; i < N0; i++) cws[i] = rnd_cw() ^ (16'h1 << i);
    prep(0, N0);
    run(0, N0, -1);
    check_res(0, N0);
    chk("single_e1", e10, 15);
    for (int i = 0; i < N0; i++) cws[i] = rnd_cw() ^ 16'h8000;
    prep(0, N0);
    run(0, N0, -1);
    check_res(0, N0);
    chk("bit15_e1", e10, 15);

    // double errors, count reaches exactly 15
    for (int i = 0; i < N0; i++) begin
      int b1 = $urandom_range(15, 0);
      int b2 = (b1 + $urandom_range(15, 1)) % 16;
      cws[i] = rnd_cw() ^ (16'h1 << b1) ^ (16'h1 << b2);
    end
    prep(0, N0);
    run(0, N0, -1);
    check_res(0, N0);
    chk("double_e2", e20, 15);

    // mixed random runs
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N0; i++) begin
        int nf = $urandom_range(2, 0);
        int b1 = $urandom_range(15, 0);
        int b2 = (b1 + $urandom_range(15, 1)) % 16;
        cws[i] = rnd_cw();
        if (nf >= 1) cws[i] ^= 16'h1 << b1;
        if (nf == 2) cws[i] ^= 16'h1 << b2;
      end
      prep(0, N0);
      run(0, N0, -1);
      check_res(0, N0);
    end

    // start pulsed while busy, then restart from DONE
    run(0, N0, 20);
    check_res(0, N0);
    run(0, N0, -1);
    check_res(0, N0);

    // reset during word 7 RD_LO
    for (int i = 0; i < 2*N0; i++) img0[DB0 + i] = 8'hA5;
    for (int i = 0; i < N0; i++) cws[i] = rnd_cw() ^ (16'h1 << (i % 16));
    prep(0, N0);
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("prerst_busy", busy0, 1);
    chk("prerst_addr", a0, SB0 + 14);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy0, 0);
    chk("rst_mid_done", done0, 0);
    chk("rst_mid_bus", {we0, a0, wd0}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N0; i++) begin
      logic [15:0] want;
      want = (i < 7) ? {exp_hi[i], exp_lo[i]} : 16'hA5A5;
      chk($sformatf("partial[%0d]", i),
          {mem0[DB0 + 2*i + 1], mem0[DB0 + 2*i]}, want);
    end
    chk("rst_counts_clr", {e10, e20}, 0);
    run(0, N0, -1);
    check_res(0, N0);

    // 20 single errors on the long instance: saturation at 15
    for (int i = 0; i < N1; i++)
      cws[i] = rnd_cw() ^ (16'h1 << $urandom_range(15, 0));
    prep(1, N1);
    run(1, N1, -1);
    check_res(1, N1);
    chk("sat_e1", e11, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
